multi_bit_sync_filt: RTL and testbench

MULTI_BIT_SYNC_FILT -- requirements
Module: multi_bit_sync_filt

---
 rtl/multi_bit_sync_filt_pkg.sv | 27 ++
 rtl/multi_bit_sync_filt_chan.sv | 67 ++++++
 rtl/multi_bit_sync_filt.sv | 40 ++++
 tb/tb_multi_bit_sync_filt.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multi_bit_sync_filt_pkg.sv
// Shared sizing helpers and legal parameter bounds for the multi-bit synchroniser/filter.
// Latency: not applicable (compile-time only).
// Backpressure: none.
package multi_bit_sync_filt_pkg;

    localparam int NUM_STAGES_MIN = 2;
    localparam int NUM_STAGES_MAX = 8;
    localparam int BUS_WIDTH_MIN  = 1;
    localparam int BUS_WIDTH_MAX  = 32;
    localparam int FILT_LEN_MIN   = 1;
    localparam int FILT_LEN_MAX   = 255;

    // Counter must hold 0..FILT_LEN; never narrower than one bit.
    function automatic int cnt_width(input int filt_len);
        if (filt_len + 1 <= 2)
            return 1;
        return $clog2(filt_len + 1);
    endfunction

    function automatic bit params_ok(input int num_stages, input int bus_width,
                                     input int filt_len);
        return (num_stages >= NUM_STAGES_MIN) && (num_stages <= NUM_STAGES_MAX) &&
               (bus_width  >= BUS_WIDTH_MIN)  && (bus_width  <= BUS_WIDTH_MAX)  &&
               (filt_len   >= FILT_LEN_MIN)   && (filt_len   <= FILT_LEN_MAX);
    endfunction

endpackage

// File: rtl/multi_bit_sync_filt_chan.sv
// One channel: NUM_STAGES synchroniser chain, persistence filter, registered level and edge pulses.
// Latency: NUM_STAGES + FILT_LEN edges from a stable input change to SYNC.
// Backpressure: none; free-running level path.
module bit_sync_chan
    import multi_bit_sync_filt_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter int   FILT_LEN   = 1,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic ASYNC,
    output logic SYNC,
    output logic RISE,
    output logic FALL
);

    localparam int            CW      = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic [NUM_STAGES-1:0] chain;
    logic                  raw;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  accept;

    assign raw = chain[NUM_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            chain <= {NUM_STAGES{RST_VAL}};
        else
            chain <= {chain[NUM_STAGES-2:0], ASYNC};
    end

    // A differing sample must persist FILT_LEN consecutive edges before it is
    // accepted; any return to the current level restarts the count.
    always_comb begin
        accept  = 1'b0;
        cnt_nxt = cnt;
        if (raw == SYNC) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_MAX) begin
            accept  = 1'b1;
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            SYNC <= RST_VAL;
            RISE <= 1'b0;
            FALL <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            RISE <= accept & raw;
            FALL <= accept & ~raw;
            if (accept)
                SYNC <= raw;
        end
    end

endmodule

// File: rtl/multi_bit_sync_filt.sv
// Bank of independent single-bit synchronisers with glitch filter and edge pulses.
// Latency: NUM_STAGES + FILT_LEN edges per channel.
// Backpressure: none; outputs are registered levels/pulses.
module multi_bit_sync_filt
    import multi_bit_sync_filt_pkg::*;
#(
    parameter int                   NUM_STAGES = 2,
    parameter int                   BUS_WIDTH  = 1,
    parameter int                   FILT_LEN   = 1,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] ASYNC,
    output logic [BUS_WIDTH-1:0] SYNC,
    output logic [BUS_WIDTH-1:0] RISE,
    output logic [BUS_WIDTH-1:0] FALL
);

    if (!params_ok(NUM_STAGES, BUS_WIDTH, FILT_LEN)) begin : g_param_err
        $error("multi_bit_sync_filt: parameter out of range (NUM_STAGES=%0d BUS_WIDTH=%0d FILT_LEN=%0d)",
               NUM_STAGES, BUS_WIDTH, FILT_LEN);
    end

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
        bit_sync_chan #(
            .NUM_STAGES (NUM_STAGES),
            .FILT_LEN   (FILT_LEN),
            .RST_VAL    (RST_VAL[i])
        ) u_chan (
            .CLK   (CLK),
            .RST   (RST),
            .ASYNC (ASYNC[i]),
            .SYNC  (SYNC[i]),
            .RISE  (RISE[i]),
            .FALL  (FALL[i])
        );
    end

endmodule

// File: tb/tb_multi_bit_sync_filt.sv
// Scoreboard bench: two configurations, expected pulse events queued by stimulus, popped by monitors.
module tb_multi_bit_sync_filt;

    typedef struct {
        int         cyc;
        logic [3:0] sync;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    logic       CLK = 1'b0;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic       rst_a, rst_b;
    logic [3:0] async_a, async_b;
    logic [3:0] sync_a, rise_a, fall_a;
    logic [3:0] sync_b, rise_b, fall_b;

    ev_t q_a[$];
    ev_t q_b[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    multi_bit_sync_filt #(
        .NUM_STAGES(2), .BUS_WIDTH(4), .FILT_LEN(3), .RST_VAL(4'h0)
    ) dut_a (
        .CLK(CLK), .RST(rst_a), .ASYNC(async_a),
        .SYNC(sync_a), .RISE(rise_a), .FALL(fall_a)
    );

    multi_bit_sync_filt #(
        .NUM_STAGES(3), .BUS_WIDTH(4), .FILT_LEN(1), .RST_VAL(4'hA)
    ) dut_b (
        .CLK(CLK), .RST(rst_b), .ASYNC(async_b),
        .SYNC(sync_b), .RISE(rise_b), .FALL(fall_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic exp_a(input int dc, input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.cyc = cyc + dc; e.sync = s; e.rise = r; e.fall = f;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input int dc, input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.cyc = cyc + dc; e.sync = s; e.rise = r; e.fall = f;
        q_b.push_back(e);
    endtask

    // Monitors: every cycle with any pulse must match the next queued event.
    always @(negedge CLK) begin
        ev_t e;
        if ((rise_a | fall_a) != 4'h0) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_pulse", {24'h0, rise_a, fall_a}, 32'h0);
            end else begin
                e = q_a.pop_front();
                chk("a_pulse_cycle", cyc, e.cyc);
                chk("a_sync", {28'h0, sync_a}, {28'h0, e.sync});
                chk("a_rise", {28'h0, rise_a}, {28'h0, e.rise});
                chk("a_fall", {28'h0, fall_a}, {28'h0, e.fall});
            end
        end
        if ((rise_b | fall_b) != 4'h0) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_pulse", {24'h0, rise_b, fall_b}, 32'h0);
            end else begin
                e = q_b.pop_front();
                chk("b_pulse_cycle", cyc, e.cyc);
                chk("b_sync", {28'h0, sync_b}, {28'h0, e.sync});
                chk("b_rise", {28'h0, rise_b}, {28'h0, e.rise});
                chk("b_fall", {28'h0, fall_b}, {28'h0, e.fall});
            end
        end
    end

    initial begin
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        async_a = 4'hF;
        async_b = 4'hA;
        step(3);
        chk("a_reset_sync", {28'h0, sync_a}, 32'h0);
        chk("a_reset_rise", {28'h0, rise_a}, 32'h0);
        chk("a_reset_fall", {28'h0, fall_a}, 32'h0);
        chk("b_reset_sync", {28'h0, sync_b}, 32'hA);

        // Release with inputs already high: all four rise together at the 5th edge.
        rst_a = 1'b0;
        exp_a(5, 4'hF, 4'hF, 4'h0);
        step(4);
        chk("a_sync_before_latency", {28'h0, sync_a}, 32'h0);
        step(4);
        chk("a_sync_after_release", {28'h0, sync_a}, 32'hF);

        // Bit 0 falls.
        async_a = 4'hE;
        exp_a(5, 4'hE, 4'h0, 4'h1);
        step(8);

        // Two-cycle glitch on bit 0: rejected.
        async_a = 4'hF;
        step(2);
        async_a = 4'hE;
        step(8);
        chk("a_glitch_rejected", {28'h0, sync_a}, 32'hE);

        // Three-cycle pulse on bit 0: accepted, three cycles wide.
        async_a = 4'hF;
        exp_a(5, 4'hF, 4'h1, 4'h0);
        step(3);
        async_a = 4'hE;
        exp_a(5, 4'hE, 4'h0, 4'h1);
        step(8);

        // Drop bit 1, then bit 1 rises while bit 2 falls.
        async_a = 4'hC;
        exp_a(5, 4'hC, 4'h0, 4'h2);
        step(8);
        async_a = 4'hA;
        exp_a(5, 4'hA, 4'h2, 4'h4);
        step(8);
        chk("a_sync_simul", {28'h0, sync_a}, 32'hA);

        // Reset with bit 0 counter at 2: outputs clear before the next edge.
        async_a = 4'hB;
        step(4);
        rst_a = 1'b1;
        #1;
        chk("a_async_reset_sync", {28'h0, sync_a}, 32'h0);
        chk("a_async_reset_rise", {28'h0, rise_a}, 32'h0);
        chk("a_async_reset_fall", {28'h0, fall_a}, 32'h0);
        async_a = 4'h0;
        step(3);
        rst_a = 1'b0;
        step(10);
        chk("a_post_reset_sync", {28'h0, sync_a}, 32'h0);

        // Second configuration: no pulses at release, then A -> 5 after 4 edges.
        rst_b = 1'b0;
        step(6);
        chk("b_sync_after_release", {28'h0, sync_b}, 32'hA);
        async_b = 4'h5;
        exp_b(4, 4'h5, 4'h5, 4'hA);
        step(3);
        chk("b_sync_before_latency", {28'h0, sync_b}, 32'hA);
        step(5);
        chk("b_sync_final", {28'h0, sync_b}, 32'h5);

        chk("a_events_pending", q_a.size(), 32'h0);
        chk("b_events_pending", q_b.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
